// File: rtl/nor_exec_pkg.sv
// Shared definitions for the NOR program executor.
//   op_e    : instruction opcode encoding carried on instr_op
//   state_e : executor control states
//   COUNT_W : width of the executed-instruction counter
package nor_exec_pkg;

  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    OP_INIT1 = 2'b00,
    OP_INIT0 = 2'b01,
    OP_NOR   = 2'b10,
    OP_NOT   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/nor_program_executor_if.sv
// Handshake bundle for the NOR program executor.
//   in_*    : primary-input vector channel (valid/ready)
//   instr_* : instruction stream channel (valid/ready), instr_last ends a program
//   out_*   : result channel (valid/ready) with result bit, error flag, count
// master = program source / result sink, slave = executor.
interface nor_program_executor_if
  import nor_exec_pkg::*;
#(
  parameter int NUM_IN = 7,
  parameter int ADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [NUM_IN-1:0]  in_bits;

  logic               instr_valid;
  logic               instr_ready;
  logic [1:0]         instr_op;
  logic [ADDR_W-1:0]  instr_a;
  logic [ADDR_W-1:0]  instr_b;
  logic [ADDR_W-1:0]  instr_dst;
  logic               instr_last;

  logic               out_valid;
  logic               out_ready;
  logic               out_bit;
  logic               out_err;
  logic [COUNT_W-1:0] out_count;

  modport master (
    output in_valid, in_bits,
    output instr_valid, instr_op, instr_a, instr_b, instr_dst, instr_last,
    output out_ready,
    input  in_ready, instr_ready,
    input  out_valid, out_bit, out_err, out_count
  );

  modport slave (
    input  in_valid, in_bits,
    input  instr_valid, instr_op, instr_a, instr_b, instr_dst, instr_last,
    input  out_ready,
    output in_ready, instr_ready,
    output out_valid, out_bit, out_err, out_count
  );

endinterface

// File: rtl/nor_cell_array.sv
// Bit-cell array with per-cell "armed" flags, modelling a memristive row.
//   clk, rst_n        : clock, asynchronous active-low reset (clears everything)
//   load_en/load_bits : bulk load of cells 0..NUM_IN-1, clears all armed flags
//   rd_a_*, rd_b_*    : two combinational read ports (out-of-range reads give 0)
//   wr_en/wr_addr     : single write port; wr_and selects cell <= cell & wr_data
//   wr_data/wr_armed  : value and armed flag written to wr_addr
//   wr_cur_armed      : current armed flag of wr_addr
//   wr_next           : value cell[wr_addr] would hold after this write
module nor_cell_array #(
  parameter int NUM_IN    = 7,
  parameter int NUM_CELLS = 32,
  parameter int ADDR_W    = $clog2(NUM_CELLS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [NUM_IN-1:0] load_bits,
  input  logic [ADDR_W-1:0] rd_a_addr,
  output logic              rd_a_data,
  input  logic [ADDR_W-1:0] rd_b_addr,
  output logic              rd_b_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  input  logic              wr_and,
  input  logic              wr_armed,
  output logic              wr_cur_armed,
  output logic              wr_next
);

  localparam logic [ADDR_W:0] CELL_LIM = (ADDR_W+1)'(NUM_CELLS);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < CELL_LIM;
  endfunction

  logic [NUM_CELLS-1:0] cell_q, cell_d;
  logic [NUM_CELLS-1:0] armed_q, armed_d;
  logic                 wr_cur_cell;

  always_comb begin
    rd_a_data    = addr_ok(rd_a_addr) ? cell_q[rd_a_addr]  : 1'b0;
    rd_b_data    = addr_ok(rd_b_addr) ? cell_q[rd_b_addr]  : 1'b0;
    wr_cur_cell  = addr_ok(wr_addr)   ? cell_q[wr_addr]    : 1'b0;
    wr_cur_armed = addr_ok(wr_addr)   ? armed_q[wr_addr]   : 1'b0;
    // A NOR-type write can only pull a cell low, never set it.
    wr_next      = wr_and ? (wr_cur_cell & wr_data) : wr_data;
  end

  always_comb begin
    cell_d  = cell_q;
    armed_d = armed_q;
    if (load_en) begin
      cell_d[NUM_IN-1:0] = load_bits;
      armed_d            = '0;
    end else if (wr_en && addr_ok(wr_addr)) begin
      cell_d[wr_addr]  = wr_next;
      armed_d[wr_addr] = wr_armed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_q  <= '0;
      armed_q <= '0;
    end else begin
      cell_q  <= cell_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/nor_program_executor.sv
// Sequential executor for NOR-only MAGIC micro-op programs.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of nor_program_executor_if
//                in_*    loads primary inputs into cells 0..NUM_IN-1
//                instr_* streams INIT1/INIT0/NOR/NOT, one per cycle
//                out_*   returns last destination value, sticky error, count
// Flow: IDLE --input accepted--> EXEC --last instruction--> DONE --out taken--> IDLE.
// Cell contents persist across runs; only the input cells are reloaded.
module nor_program_executor
  import nor_exec_pkg::*;
#(
  parameter int NUM_IN    = 7,
  parameter int NUM_CELLS = 32,
  parameter int ADDR_W    = $clog2(NUM_CELLS)
) (
  input logic                 clk,
  input logic                 rst_n,
  nor_program_executor_if.slave bus
);

  localparam logic [ADDR_W:0] CELL_LIM = (ADDR_W+1)'(NUM_CELLS);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return {1'b0, addr} < CELL_LIM;
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  state_e             state_q, state_d;
  logic               out_bit_q, out_bit_d;
  logic               err_q, err_d;
  logic [COUNT_W-1:0] count_q, count_d;

  op_e               op;
  logic              in_fire, instr_fire, out_fire;
  logic              is_nor_like, addr_bad;
  logic [ADDR_W-1:0] rd_b_addr;
  logic              rd_a_data, rd_b_data;
  logic              wr_en, wr_data, wr_and, wr_armed;
  logic              dst_armed, wr_next;

  assign op         = op_e'(bus.instr_op);
  assign in_fire    = (state_q == S_IDLE) && bus.in_valid;
  assign instr_fire = (state_q == S_EXEC) && bus.instr_valid;
  assign out_fire   = (state_q == S_DONE) && bus.out_ready;

  // Instruction decode. Only addresses an opcode actually uses are checked,
  // so don't-care fields (b for INIT/NOT, a for INIT) never raise an error.
  always_comb begin
    is_nor_like = (op == OP_NOR) || (op == OP_NOT);
    rd_b_addr   = (op == OP_NOT) ? bus.instr_a : bus.instr_b;
    addr_bad    = !addr_ok(bus.instr_dst)
                || (is_nor_like && !addr_ok(bus.instr_a))
                || ((op == OP_NOR) && !addr_ok(bus.instr_b));
    wr_en       = instr_fire && !addr_bad;
    wr_and      = is_nor_like;
    wr_data     = is_nor_like ? ~(rd_a_data | rd_b_data) : (op == OP_INIT1);
    wr_armed    = (op == OP_INIT1);
  end

  nor_cell_array #(
    .NUM_IN   (NUM_IN),
    .NUM_CELLS(NUM_CELLS),
    .ADDR_W   (ADDR_W)
  ) u_cells (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en     (in_fire),
    .load_bits   (bus.in_bits),
    .rd_a_addr   (bus.instr_a),
    .rd_a_data   (rd_a_data),
    .rd_b_addr   (rd_b_addr),
    .rd_b_data   (rd_b_data),
    .wr_en       (wr_en),
    .wr_addr     (bus.instr_dst),
    .wr_data     (wr_data),
    .wr_and      (wr_and),
    .wr_armed    (wr_armed),
    .wr_cur_armed(dst_armed),
    .wr_next     (wr_next)
  );

  // Result bookkeeping: cleared when a new input vector is taken, held in DONE.
  always_comb begin
    err_d     = err_q;
    count_d   = count_q;
    out_bit_d = out_bit_q;
    if (in_fire) begin
      err_d     = 1'b0;
      count_d   = '0;
      out_bit_d = 1'b0;
    end else if (instr_fire) begin
      count_d = sat_inc(count_q);
      // Evaluating into an un-initialised cell is a program bug, but the
      // AND-write still happens so the array matches the crossbar.
      if (addr_bad || (is_nor_like && !dst_armed)) err_d = 1'b1;
      if (bus.instr_last) out_bit_d = addr_bad ? 1'b0 : wr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      out_bit_q <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      out_bit_q <= out_bit_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_fire) state_d = S_EXEC;
      S_EXEC:  if (instr_fire && bus.instr_last) state_d = S_DONE;
      S_DONE:  if (out_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready    = (state_q == S_IDLE);
    bus.instr_ready = (state_q == S_EXEC);
    bus.out_valid   = (state_q == S_DONE);
  end

  assign bus.out_bit   = out_bit_q;
  assign bus.out_err   = err_q;
  assign bus.out_count = count_q;

endmodule

// File: tb/tb_nor_program_executor.sv
// Directed bench for nor_program_executor: a table of programs with
// hand-computed results, plus hand-written reset, backpressure and
// mid-run reset sequences.
module tb_nor_program_executor;
  import nor_exec_pkg::*;

  localparam int NUM_IN    = 7;
  localparam int NUM_CELLS = 24;
  localparam int ADDR_W    = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nor_program_executor_if #(.NUM_IN(NUM_IN), .ADDR_W(ADDR_W)) bus ();

  nor_program_executor #(
    .NUM_IN   (NUM_IN),
    .NUM_CELLS(NUM_CELLS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] dst;
  } instr_t;

  typedef struct {
    string       name;
    logic [6:0]  bits;
    int          first;
    int          n;
    logic        exp_bit;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  instr_t itab[$];
  vec_t   vecs[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void ins(input logic [1:0] op, input logic [4:0] a,
                              input logic [4:0] b, input logic [4:0] dst);
    instr_t t;
    t.op = op; t.a = a; t.b = b; t.dst = dst;
    itab.push_back(t);
  endfunction

  // Records the program made of the last n instructions pushed by ins().
  function automatic void addv(input string name, input logic [6:0] bits, input int n,
                               input logic eb, input logic ee, input logic [15:0] ec);
    vec_t v;
    v.name = name; v.bits = bits; v.first = itab.size() - n; v.n = n;
    v.exp_bit = eb; v.exp_err = ee; v.exp_cnt = ec;
    vecs.push_back(v);
  endfunction

  task automatic load(input logic [6:0] bits);
    chk1("in_ready_idle", bus.in_ready, 1'b1);
    bus.in_bits  = bits;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk1("in_ready_exec", bus.in_ready, 1'b0);
  endtask

  // Consecutive calls keep instr_valid high across edges: no bubbles.
  task automatic issue(input instr_t t, input logic last);
    bus.instr_valid = 1'b1;
    bus.instr_op    = t.op;
    bus.instr_a     = t.a;
    bus.instr_b     = t.b;
    bus.instr_dst   = t.dst;
    bus.instr_last  = last;
    chk1("instr_ready", bus.instr_ready, 1'b1);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.instr_last  = 1'b0;
  endtask

  task automatic finish_run(input string name, input logic eb, input logic ee,
                            input logic [15:0] ec);
    int k;
    chk1({name, "_latency"}, bus.out_valid, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk1({name, "_bit"}, bus.out_bit, eb);
    chk1({name, "_err"}, bus.out_err, ee);
    chk16({name, "_count"}, bus.out_count, ec);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk1({name, "_out_valid_low"}, bus.out_valid, 1'b0);
  endtask

  task automatic check_reset_vals(input string name);
    chk1({name, "_in_ready"}, bus.in_ready, 1'b1);
    chk1({name, "_instr_ready"}, bus.instr_ready, 1'b0);
    chk1({name, "_out_valid"}, bus.out_valid, 1'b0);
    chk1({name, "_out_bit"}, bus.out_bit, 1'b0);
    chk1({name, "_out_err"}, bus.out_err, 1'b0);
    chk16({name, "_out_count"}, bus.out_count, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_bits     = '0;
    bus.instr_valid = 1'b0;
    bus.instr_op    = '0;
    bus.instr_a     = '0;
    bus.instr_b     = '0;
    bus.instr_dst   = '0;
    bus.instr_last  = 1'b0;
    bus.out_ready   = 1'b0;

    // Program table. Cells persist between runs, so order matters.
    ins(OP_INIT1, 0, 0, 10); ins(OP_NOR, 0, 1, 10);
    addv("basic_nor", 7'b0000000, 2, 1'b1, 1'b0, 16'd2);
    ins(OP_INIT1, 0, 0, 10); ins(OP_NOR, 0, 1, 10);
    addv("reset_only", 7'b0000010, 2, 1'b0, 1'b0, 16'd2);
    ins(OP_NOR, 0, 2, 10);
    addv("unarmed_nor", 7'b0000000, 1, 1'b0, 1'b1, 16'd1);
    ins(OP_INIT1, 0, 0, 10); ins(OP_NOT, 3, 0, 10);
    ins(OP_INIT1, 0, 0, 11); ins(OP_NOR, 10, 10, 11);
    addv("b2b_not", 7'b0001000, 4, 1'b1, 1'b0, 16'd4);
    ins(OP_INIT1, 0, 0, 12); ins(OP_INIT0, 0, 0, 12); ins(OP_NOR, 0, 0, 12);
    addv("init0_disarms", 7'b0000000, 3, 1'b0, 1'b1, 16'd3);
    ins(OP_INIT1, 0, 0, 13); ins(OP_NOT, 6, 0, 13);
    addv("not_of_one", 7'b1111111, 2, 1'b0, 1'b0, 16'd2);
    ins(OP_INIT1, 0, 0, 15);
    addv("last_is_init", 7'b0000000, 1, 1'b1, 1'b0, 16'd1);
    ins(OP_INIT1, 0, 0, 14); ins(OP_NOR, 14, 0, 14);
    addv("dst_eq_src", 7'b0000000, 2, 1'b0, 1'b0, 16'd2);
    ins(OP_INIT1, 0, 0, 24);
    addv("bad_dst", 7'b0000000, 1, 1'b0, 1'b1, 16'd1);
    ins(OP_INIT1, 0, 0, 16); ins(OP_NOR, 1, 25, 16);
    addv("bad_src", 7'b0000010, 2, 1'b0, 1'b1, 16'd2);
    // cell16 must still be 1 after the rejected write above.
    ins(OP_INIT1, 0, 0, 17); ins(OP_NOR, 16, 16, 17);
    addv("bad_src_nowrite", 7'b0000000, 2, 1'b0, 1'b0, 16'd2);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      load(vecs[i].bits);
      for (int j = 0; j < vecs[i].n; j++)
        issue(itab[vecs[i].first + j], (j == vecs[i].n - 1));
      finish_run(vecs[i].name, vecs[i].exp_bit, vecs[i].exp_err, vecs[i].exp_cnt);
    end

    // Backpressure: result held for 5 cycles while junk is offered on inputs.
    begin
      instr_t t;
      load(7'b0000001);
      t.op = OP_INIT1; t.a = 0; t.b = 0; t.dst = 21; issue(t, 1'b0);
      t.op = OP_NOT;   t.a = 1; t.b = 0; t.dst = 21; issue(t, 1'b1);
      bus.in_valid    = 1'b1;
      bus.instr_valid = 1'b1;
      bus.instr_op    = OP_INIT0;
      bus.instr_dst   = 5'd21;
      bus.instr_last  = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        chk1("bp_out_valid", bus.out_valid, 1'b1);
        chk1("bp_out_bit", bus.out_bit, 1'b1);
        chk1("bp_out_err", bus.out_err, 1'b0);
        chk16("bp_out_count", bus.out_count, 16'd2);
        chk1("bp_in_ready", bus.in_ready, 1'b0);
        chk1("bp_instr_ready", bus.instr_ready, 1'b0);
      end
      bus.in_valid    = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr_last  = 1'b0;
      finish_run("bp_release", 1'b1, 1'b0, 16'd2);
      chk1("bp_back_idle", bus.in_ready, 1'b1);
    end

    // Reset in the middle of a run, after three accepted instructions.
    begin
      instr_t t;
      load(7'b0000000);
      t.op = OP_INIT1; t.a = 0; t.b = 0;
      t.dst = 18; issue(t, 1'b0);
      t.dst = 19; issue(t, 1'b0);
      t.dst = 20; issue(t, 1'b0);
      chk16("midrun_count", bus.out_count, 16'd3);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrun_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      // cell15 was set to 1 earlier; reset must have cleared it.
      load(7'b0000000);
      t.op = OP_INIT1; t.a = 0;  t.b = 0;  t.dst = 19; issue(t, 1'b0);
      t.op = OP_NOR;   t.a = 15; t.b = 15; t.dst = 19; issue(t, 1'b1);
      finish_run("post_reset", 1'b1, 1'b0, 16'd2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
